// File: rtl/net_rx_packet_buffer.sv
// Store-and-forward RX packet FIFO: always accepts beats, releases only complete
// packets downstream, and drops whole packets that do not fit.
module net_rx_packet_buffer #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_data,
  input  logic [7:0]           in_keep,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_data,
  output logic [7:0]           out_keep,
  output logic                 out_last,
  output logic [ADDR_BITS:0]   pkt_count,
  output logic [31:0]          drop_count
);

  localparam int PW = ADDR_BITS + 1;

  typedef enum logic {ACCEPT, DROP} state_t;
  typedef logic [PW-1:0] ptr_t;

  state_t      state_q, state_d;
  ptr_t        wr_q, wr_d;
  ptr_t        commit_q, commit_d;
  ptr_t        rd_q, rd_d;
  ptr_t        pkt_q, pkt_d;
  logic [31:0] drop_q, drop_d;
  logic [72:0] mem_q [DEPTH];

  logic        wr_en;
  logic        in_fire;
  logic        out_fire;
  logic        pkt_commit;
  logic        pkt_release;
  ptr_t        used;
  ptr_t        free_space;
  logic [72:0] rd_entry;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign in_ready   = ~reset;
  assign in_fire    = in_valid & in_ready;
  // Space is judged against rd_q before this cycle's read, so a same-cycle
  // release never makes room for a same-cycle write.
  assign used       = wr_q - rd_q;
  assign free_space = ptr_t'(DEPTH) - used;

  assign rd_entry   = mem_q[rd_q[ADDR_BITS-1:0]];
  assign out_valid  = (pkt_q != '0);
  assign {out_last, out_keep, out_data} = rd_entry;
  assign out_fire   = out_valid & out_ready;

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    commit_d    = commit_q;
    rd_d        = rd_q;
    drop_d      = drop_q;
    wr_en       = 1'b0;
    pkt_commit  = 1'b0;
    pkt_release = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (in_fire) begin
          if (free_space != '0) begin
            wr_en = 1'b1;
            wr_d  = wr_q + 1'b1;
            if (in_last) begin
              commit_d   = wr_q + 1'b1;
              pkt_commit = 1'b1;
            end
          end else begin
            // Overflow: discard everything written for this packet so far.
            wr_d = commit_q;
            if (in_last) begin
              drop_d = sat_inc32(drop_q);
            end else begin
              state_d = DROP;
            end
          end
        end
      end
      DROP: begin
        wr_d = commit_q;
        if (in_fire && in_last) begin
          drop_d  = sat_inc32(drop_q);
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase

    if (out_fire) begin
      rd_d        = rd_q + 1'b1;
      pkt_release = out_last;
    end

    case ({pkt_commit, pkt_release})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ACCEPT;
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      pkt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
      pkt_q    <= pkt_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_q[ADDR_BITS-1:0]] <= {in_last, in_keep, in_data};
    end
  end

endmodule

// File: tb/tb_net_rx_packet_buffer.sv
// Scoreboard bench for net_rx_packet_buffer at DEPTH=8: expected beats are queued
// as packets are sent and compared as the DUT releases them.
module tb_net_rx_packet_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_last;
  logic [3:0]  pkt_count;
  logic [31:0] drop_count;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    errors = 0;
  int    checks = 0;
  int    fires  = 0;
  int    exp_drops = 0;

  always #5 clock = ~clock;

  net_rx_packet_buffer #(.DEPTH(8), .ADDR_BITS(3)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  // Scoreboard monitor: a fire seen here completes on the next rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      fires++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data=%h keep=%h last=%b, required no beat",
                 out_data, out_keep, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_last, out_keep, out_data} !== mon_e) begin
          errors++;
          $display("FAIL sb_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                   out_data, out_keep, out_last, mon_e.data, mon_e.keep, mon_e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [63:0] base, input bit stored);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = base + 64'(i);
      b.keep = 8'hFF;
      b.last = (i == len - 1);
      if (stored) exp_q.push_back(b);
      send_beat(b.data, b.keep, b.last);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (pkt_count !== 4'd0 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_idle: got pkt_count=%0d out_valid=%b pending=%0d, required 0/0/0",
               name, pkt_count, out_valid, exp_q.size());
    end
    checks++;
    if (drop_count !== 32'(exp_drops)) begin
      errors++;
      $display("FAIL %s_drops: got %0d, required %0d", name, drop_count, exp_drops);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || pkt_count !== 4'd0 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b pkt=%0d drop=%0d, required 0/0/0/0",
               in_ready, out_valid, pkt_count, drop_count);
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    beat_t b;
    out_ready = 1'b1;
    b = '{1'b0, 8'hFF, 64'd1}; exp_q.push_back(b);
    b = '{1'b0, 8'hFF, 64'd2}; exp_q.push_back(b);
    b = '{1'b1, 8'h0F, 64'd3}; exp_q.push_back(b);
    send_beat(64'd1, 8'hFF, 1'b0);
    send_beat(64'd2, 8'hFF, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== 4'd0) begin
      errors++;
      $display("FAIL basic_early: got out_valid=%b pkt=%0d, required 0/0", out_valid, pkt_count);
    end
    send_beat(64'd3, 8'h0F, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || pkt_count !== 4'd1) begin
      errors++;
      $display("FAIL basic_commit: got out_valid=%b pkt=%0d, required 1/1", out_valid, pkt_count);
    end
    wait_cycles(4);
    check_idle("basic");
  endtask

  task automatic test_overflow;
    int f0;
    out_ready = 1'b0;
    send_pkt(6, 64'h100, 1'b1);
    send_pkt(4, 64'h200, 1'b0);
    exp_drops++;
    checks++;
    if (drop_count !== 32'(exp_drops) || pkt_count !== 4'd1) begin
      errors++;
      $display("FAIL ovf_counts: got drop=%0d pkt=%0d, required %0d/1", drop_count, pkt_count, exp_drops);
    end
    f0 = fires;
    out_ready = 1'b1;
    wait_cycles(10);
    checks++;
    if (fires - f0 != 6) begin
      errors++;
      $display("FAIL ovf_fires: got %0d, required 6", fires - f0);
    end
    checks++;
    if (dut.wr_q !== dut.rd_q) begin
      errors++;
      $display("FAIL ovf_ptrs: got wr=%0d rd=%0d, required equal", dut.wr_q, dut.rd_q);
    end
    check_idle("ovf");
  endtask

  task automatic test_long_pkt;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_beat(64'h300 + 64'(i), 8'hFF, (i == 8));
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL long_valid: got out_valid=%b after beat %0d, required 0", out_valid, i);
      end
    end
    exp_drops++;
    checks++;
    if (drop_count !== 32'(exp_drops)) begin
      errors++;
      $display("FAIL long_drop: got %0d, required %0d", drop_count, exp_drops);
    end
    send_pkt(2, 64'h400, 1'b1);
    wait_cycles(4);
    check_idle("long");
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = fires;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_pkt(1, 64'h500 + 64'(i), 1'b1);
      checks++;
      if (pkt_count > 4'd1) begin
        errors++;
        $display("FAIL b2b_pkt: got pkt_count=%0d at %0d, required <=1", pkt_count, i);
      end
    end
    wait_cycles(3);
    checks++;
    if (fires - f0 != 20) begin
      errors++;
      $display("FAIL b2b_fires: got %0d, required 20", fires - f0);
    end
    check_idle("b2b");
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send_pkt(2, 64'h600, 1'b1);
    send_beat(64'h700, 8'hFF, 1'b0);
    send_beat(64'h701, 8'hFF, 1'b0);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_drops = 0;
    checks++;
    if (out_valid !== 1'b0 || pkt_count !== 4'd0 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_state: got out_valid=%b pkt=%0d drop=%0d, required 0/0/0",
               out_valid, pkt_count, drop_count);
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    send_pkt(2, 64'h800, 1'b1);
    wait_cycles(4);
    check_idle("rstmid");
  endtask

  task automatic test_stall;
    int          f0;
    logic [63:0] held;
    logic        stall;
    out_ready = 1'b0;
    send_pkt(5, 64'h900, 1'b1);
    f0 = fires;
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      @(negedge clock);
      held  = out_data;
      stall = out_valid && !out_ready;
      @(posedge clock); #1;
      if (stall) begin
        checks++;
        if (out_data !== held || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got data=%h valid=%b, required data=%h valid=1",
                   out_data, out_valid, held);
        end
      end
    end
    checks++;
    if (fires - f0 != 5) begin
      errors++;
      $display("FAIL stall_fires: got %0d, required 5", fires - f0);
    end
    check_idle("stall");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_long_pkt();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/net_rx_packet_buffer.md
Name: net_rx_packet_buffer

Overview:
- Store-and-forward packet FIFO on the RX path, directly downstream of the simulated network endpoint's net_in stream and upstream of the NIC receive logic.
- The endpoint cannot be back-pressured meaningfully, so this block always accepts beats.
- It releases only complete packets downstream.
- It drops whole packets that do not fit.

Parameters:
- DEPTH, 64, buffer capacity in beats; power of two, at least 4.
- ADDR_BITS, 6, log2(DEPTH).

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  beat from network endpoint
- in_ready  output  1  constant 1 out of reset, 0 during reset
- in_data  input  64  beat payload
- in_keep  input  8  byte enables
- in_last  input  1  final beat of packet
- out_valid  output  1  beat available to NIC
- out_ready  input  1  NIC accepts beat
- out_data  output  64  payload
- out_keep  output  8  byte enables
- out_last  output  1  final beat
- pkt_count  output  ADDR_BITS+1  complete packets buffered
- drop_count  output  32  packets dropped, saturating

Behaviour:
- Storage: DEPTH entries of {last, keep[7:0], data[63:0]}.
- Pointers, each ADDR_BITS+1 wide:
  - wr_ptr: next write slot.
  - commit_ptr: first beat of the in-progress packet.
  - rd_ptr: next beat to send.
- Free space = DEPTH - (wr_ptr - rd_ptr), computed modulo 2^(ADDR_BITS+1).
- Reset (asynchronous): all pointers 0, pkt_count 0, drop_count 0, state ACCEPT, out_valid 0.
  - Any partially written packet is lost.
  - Memory contents need not be reset.
- Input beat fires when in_valid && in_ready.
- State ACCEPT:
  - Fire with free space > 0: write the beat at wr_ptr; wr_ptr += 1.
  - If that beat has in_last: commit_ptr <= wr_ptr + 1 and pkt_count += 1.
  - Fire with free space == 0: do not write; wr_ptr <= commit_ptr (rewind), then:
    - If in_last: drop_count += 1 and stay in ACCEPT.
    - Otherwise go to DROP.
- State DROP:
  - Discard all beats.
  - On a fire with in_last: drop_count += 1, go to ACCEPT.
  - wr_ptr stays equal to commit_ptr.
- Packets longer than DEPTH beats are therefore always dropped. No beat of a dropped packet is ever visible downstream.
- Output side:
  - out_valid = (pkt_count != 0).
  - out_{data,keep,last} are read combinationally from entry rd_ptr. Zero-cycle latency from head of queue; minimum latency from input last-beat to out_valid is 1 cycle.
  - Output fire (out_valid && out_ready): rd_ptr += 1.
  - If the fired beat has out_last: pkt_count -= 1.
- Simultaneous input commit and output last-beat release in the same cycle: pkt_count unchanged.
- Free space is evaluated using rd_ptr before this cycle's read, i.e. a read in the same cycle does not create space for a same-cycle write.
- out_valid, once high, stays high until the packet's last beat fires; out data is stable while out_valid && !out_ready.
- Pointer wrap-around is natural modulo 2^(ADDR_BITS+1); full is distinguished from empty by the MSB.
- drop_count saturates at 0xFFFFFFFF.
- in_ready is never deasserted outside reset; protocol violations upstream (in_keep == 0) are stored as-is.

Test Plan:
- DEPTH=8, one 3-beat packet (data 1,2,3; keep FF,FF,0F; last on beat 3), out_ready=1:
  - out_valid rises the cycle after beat 3.
  - Beats emerge 1,2,3 with keep FF,FF,0F.
  - pkt_count goes 0→1→0; drop_count stays 0.
- DEPTH=8, out_ready=0, send a 6-beat packet A, then a 4-beat packet B:
  - A is stored; B overflows at its 3rd beat and is dropped.
  - drop_count=1, pkt_count=1.
  - After raising out_ready, only A's 6 beats emerge; wr_ptr equals rd_ptr afterwards.
- DEPTH=8, a 9-beat packet with empty buffer:
  - Dropped; drop_count=1; out_valid never asserts.
  - A following 2-beat packet passes intact.
- DEPTH=8, back-to-back 1-beat packets with out_ready=1 continuous for 20 cycles:
  - Every packet is delivered in order.
  - pkt_count ≤ 1 throughout; covers pointer wrap twice.
  - Covers simultaneous commit/release.
- Assert reset mid-packet (after beat 2 of 4) with one complete packet buffered:
  - Outputs go to out_valid=0, pkt_count=0, drop_count=0 immediately.
  - After release, a new 2-beat packet is delivered correctly, with no stale beats.
- DEPTH=8, out_ready toggling every cycle while a 5-beat packet drains:
  - out_data is held stable during stalls.
  - Exactly 5 fires occur, with last on the 5th.
